demux_1to4: RTL and testbench
=============================

Name: demux_1to4

Overview:
- 1-input, 4-output demultiplexer with registered outputs.
- Select {s1,s0} steers data input i onto exactly one of d0..d3; the other three outputs are driven to 0.
- Sits between a single producer and four consumers in the datapath.
- Also provides a one-hot copy of the registered select code, for downstream consumers and for verification.

Parameters:
- WIDTH, 1, bit width of data input i and of each data output d0..d3.
- REG_OUT, 1, 1 = outputs registered (one-cycle latency); 0 = outputs purely combinational from inputs, with clk/rst_n unused by the data path.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  routing enable; when 0, all data outputs are 0.
- s0  input  1  select bit 0 (LSB).
- s1  input  1  select bit 1 (MSB).
- i  input  WIDTH  data input.
- d0  output  WIDTH  routed data when {s1,s0}=00, else 0.
- d1  output  WIDTH  routed data when {s1,s0}=01, else 0.
- d2  output  WIDTH  routed data when {s1,s0}=10, else 0.
- d3  output  WIDTH  routed data when {s1,s0}=11, else 0.
- sel_oh  output  4  one-hot select: bit k set when code k is active and en=1, else 4'b0000.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Select code sel = {s1,s0}: 0 to d0, 1 to d1, 2 to d2, 3 to d3.
- Combinational next-value function:
  - For each k: dk_next = (en && sel==k) ? i : 0.
  - sel_oh_next = en ? (4'b0001 << sel) : 4'b0000.
- REG_OUT=1:
  - On each rising clk edge, d0..d3 and sel_oh load their next values.
  - Latency is exactly one cycle from an input change to the output.
  - Outputs are glitch-free between edges.
- REG_OUT=0:
  - Outputs equal the next values continuously (zero latency).
  - rst_n has no effect on the outputs.
- Reset (REG_OUT=1):
  - rst_n low forces d0=d1=d2=d3=0 and sel_oh=4'b0000 immediately, without waiting for a clock edge.
  - Outputs hold these values while rst_n is low.
  - The first load after rst_n deasserts happens at the next rising edge.
  - Reset asserted mid-operation clears the outputs asynchronously; no partial state is retained.
- Exclusivity: at most one of d0..d3 is nonzero at any time, and sel_oh has at most one bit set.
- en=0: all outputs go to 0 (after one edge when REG_OUT=1) regardless of sel and i.
- i=0 with en=1: the selected output is 0; sel_oh still flags the selected code.
- Simultaneous change of sel and i in one cycle: the output reflects the new sel and new i after one edge; no intermediate value ever appears on a non-selected output.
- Inputs are synchronous to clk; no internal synchronizers.
- No X propagation requirement on an unknown select: the implementation drives 0 on all outputs whenever sel is not a valid binary code.

Test Plan:
1. Reset: rst_n=0 asynchronously with no clk edge → d0..d3=0 and sel_oh=0000 immediately; hold 3 cycles; release → still 0 until the next edge.
2. Select sweep (WIDTH=1, en=1, i=1), sel stepped 00, 01, 10, 11, 00, one per cycle → one cycle later:
   - d0=1, then d1=1, then d2=1, then d3=1, then d0=1;
   - the other three outputs are 0 at every step;
   - sel_oh = 0001, 0010, 0100, 1000, 0001.
3. Enable gating: en=0, i=1, sel=10 → all d=0 and sel_oh=0000; raise en → d2=1 after one edge.
4. Data pass-through (WIDTH=8), sel=11, i=8'hA5 then 8'h3C → d3=A5 then 3C on consecutive cycles; d0..d2=0.
5. Mid-operation reset: sel=01, i=1 streaming; assert rst_n between edges → d1 drops to 0 without a clock; deassert → d1=1 at the following edge.
6. Combinational variant REG_OUT=0: toggle sel through 00..11 with i=1 → outputs follow within the same delta, independent of clk and rst_n.

Source files
------------

// File: rtl/demux_1to4.sv
// 1-to-4 demultiplexer: steers i onto the output picked by {s1,s0}, zeroing the rest.
// Optional output register stage with asynchronous active-low reset.
module demux_1to4 #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [3:0]       sel_oh
);

  // No handshake: every clock edge (or every input change when unregistered)
  // presents a new output word; there is no valid/ready flow control.
  logic [1:0]       sel;
  logic [WIDTH-1:0] d0_d, d1_d, d2_d, d3_d;
  logic [3:0]       sel_oh_d;

  assign sel = {s1, s0};

  // An unknown select code falls to the default branch and drives all zeros.
  always_comb begin
    d0_d     = '0;
    d1_d     = '0;
    d2_d     = '0;
    d3_d     = '0;
    sel_oh_d = 4'b0000;
    if (en) begin
      case (sel)
        2'b00: begin d0_d = i; sel_oh_d = 4'b0001; end
        2'b01: begin d1_d = i; sel_oh_d = 4'b0010; end
        2'b10: begin d2_d = i; sel_oh_d = 4'b0100; end
        2'b11: begin d3_d = i; sel_oh_d = 4'b1000; end
        default: ;
      endcase
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] d0_q, d1_q, d2_q, d3_q;
      logic [3:0]       sel_oh_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d0_q     <= '0;
          d1_q     <= '0;
          d2_q     <= '0;
          d3_q     <= '0;
          sel_oh_q <= 4'b0000;
        end else begin
          d0_q     <= d0_d;
          d1_q     <= d1_d;
          d2_q     <= d2_d;
          d3_q     <= d3_d;
          sel_oh_q <= sel_oh_d;
        end
      end

      assign d0     = d0_q;
      assign d1     = d1_q;
      assign d2     = d2_q;
      assign d3     = d3_q;
      assign sel_oh = sel_oh_q;
    end else begin : g_comb
      // Clock and reset play no part in the purely combinational variant.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign d0     = d0_d;
      assign d1     = d1_d;
      assign d2     = d2_d;
      assign d3     = d3_d;
      assign sel_oh = sel_oh_d;
    end
  endgenerate

endmodule

// File: tb/tb_demux_1to4.sv
// Bench for demux_1to4: registered instance checked through an expected-value
// queue, combinational instance checked directly against the same reference.
module tb_demux_1to4;
  localparam int W  = 8;
  localparam int PW = 4 * W + 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         en, s0, s1;
  logic [W-1:0] i;
  logic [W-1:0] d0, d1, d2, d3, c0, c1, c2, c3;
  logic [3:0]   sel_oh, c_oh;

  demux_1to4 #(.WIDTH(W), .REG_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s0(s0), .s1(s1), .i(i),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .sel_oh(sel_oh)
  );

  demux_1to4 #(.WIDTH(W), .REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .s0(s0), .s1(s1), .i(i),
    .d0(c0), .d1(c1), .d2(c2), .d3(c3), .sel_oh(c_oh)
  );

  // scoreboard state
  logic [PW-1:0] exp_q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  bit            mon_en = 1'b0;

  // Reference: output k carries the data only when enabled and k is the code.
  function automatic logic [PW-1:0] model(input logic e, input int code, input logic [W-1:0] x);
    logic [W-1:0] d [4];
    logic [3:0]   oh;
    oh = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      d[k]  = (e && code == k) ? x : '0;
      oh[k] = (e && code == k);
    end
    return {d[3], d[2], d[1], d[0], oh};
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] reg_out();
    return {d3, d2, d1, d0, sel_oh};
  endfunction

  function automatic logic [PW-1:0] comb_out();
    return {c3, c2, c1, c0, c_oh};
  endfunction

  // driver: apply one input word between edges, queue the response for the next edge
  task automatic drive(input logic e, input int code, input logic [W-1:0] x);
    @(negedge clk);
    en = e;
    {s1, s0} = code[1:0];
    i = x;
    exp_q.push_back(model(e, code, x));
    #1 check("comb_follow", comb_out(), model(e, code, x));
  endtask

  // monitor: every registered edge presents one output word
  always @(posedge clk) begin
    #1;
    if (mon_en && exp_q.size() > 0) begin
      logic [PW-1:0] exp;
      int nz;
      exp = exp_q.pop_front();
      check("reg_out", reg_out(), exp);
      nz = (d0 != 0) + (d1 != 0) + (d2 != 0) + (d3 != 0);
      n_cmp++;
      if (nz > 1 || $countones(sel_oh) > 1) begin
        n_fail++;
        $display("FAIL exclusive: got %0d nonzero outputs, sel_oh %b, required at most one", nz, sel_oh);
      end
    end
  end

  initial begin
    int wait_cyc;
    rst_n = 1'b1;
    en = 1'b1; {s1, s0} = 2'b10; i = 8'hFF;

    // async reset before any clock edge
    #2 rst_n = 1'b0;
    #1 check("reset_async", reg_out(), '0);
    check("comb_ignores_reset", comb_out(), model(1'b1, 2, 8'hFF));
    repeat (3) begin
      @(posedge clk); #2;
      check("reset_hold", reg_out(), '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release", reg_out(), '0);
    mon_en = 1'b1;

    // select sweep
    drive(1'b1, 0, 8'h01);
    drive(1'b1, 1, 8'h01);
    drive(1'b1, 2, 8'h01);
    drive(1'b1, 3, 8'h01);
    drive(1'b1, 0, 8'h01);
    // enable gating, zero data, pass-through
    drive(1'b0, 2, 8'h01);
    drive(1'b1, 2, 8'h01);
    drive(1'b1, 1, 8'h00);
    drive(1'b1, 3, 8'hA5);
    drive(1'b1, 3, 8'h3C);

    // mid-operation reset while streaming to d1
    drive(1'b1, 1, 8'h01);
    drive(1'b1, 1, 8'h01);
    @(posedge clk); #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1 check("reset_midop", reg_out(), '0);
    check("comb_midop", comb_out(), model(1'b1, 1, 8'h01));
    @(posedge clk); #2;
    check("reset_midop_hold", reg_out(), '0);
    rst_n = 1'b1;
    #1 check("reset_midop_release", reg_out(), '0);
    mon_en = 1'b1;
    drive(1'b1, 1, 8'h01);

    // randomized traffic
    for (int n = 0; n < 300; n++)
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), W'($urandom));

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
